apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_wait_timer.sv | 39 +++
 rtl/apb_master.sv | 134 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state type and default bus widths for the APB master
package apb_pkg;

    localparam int DEFAULT_AMBA_WORD       = 32;
    localparam int DEFAULT_AMBA_ADDR_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - counts stalled ACCESS cycles and flags the last allowed one
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on a new transfer, step on every stalled ACCESS cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the stalled cycle that would make the count reach LIMIT
    assign expired_o = inc_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - command-driven APB master; APB_MASTER_TIMEOUT_EN adds an ACCESS timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = DEFAULT_AMBA_WORD,
    parameter int AMBA_ADDR_WIDTH = DEFAULT_AMBA_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_t                 state_q, state_d;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                       pwrite_q, pwrite_d;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_err_q, rsp_err_d;
    logic                       handshake;
    logic                       timeout_hit;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign handshake = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic access_stall;

    assign access_stall = (state_q == ACCESS) && !PREADY;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (handshake),
        .inc_i     (access_stall),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and transfer bookkeeping; PREADY is checked before the timeout so it wins
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d  = SETUP;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bus registers; reset aborts any transfer without a response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
